// File: rtl/axis_burst_reader_pkg.sv
// Shared types and constants for the AXIS burst reader.
package axis_burst_reader_pkg;

   // Reader FSM states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   // Width of the completed-burst statistics counters
   localparam int CNT_W = 16;

endpackage

// File: rtl/axis_burst_reader_timer.sv
// Idle flush timer: counts idle cycles while residue sits in the FIFO and
// reports when the programmed timeout has been reached.
module axis_flush_timer #(
   parameter int TIMEOUT_BITS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_i,     // burst starting this cycle
   input  logic                    count_i,     // FSM idle, allowed to count
   input  logic                    avail_nz_i,  // FIFO holds at least one word
   input  logic [TIMEOUT_BITS-1:0] cfg_timeout_i,
   output logic                    expired_o
);

   logic [TIMEOUT_BITS-1:0] timer_q, timer_d;

   // Next timer value: saturates at the timeout, cleared when nothing is waiting
   always_comb begin
      timer_d = timer_q;
      if (clear_i || !avail_nz_i || (cfg_timeout_i == '0))
         timer_d = '0;
      else if (count_i && (timer_q < cfg_timeout_i))
         timer_d = timer_q + TIMEOUT_BITS'(1);
   end

   // Timer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end

   // Timeout of zero means the flush path is switched off
   always_comb begin
      expired_o = (cfg_timeout_i != '0) && avail_nz_i && (timer_q == cfg_timeout_i);
   end

endmodule

// File: rtl/axis_burst_reader.sv
// Drains an AXIS FIFO as fixed-length bursts framed with m_tlast. A burst
// starts only once a whole burst is buffered; an idle timeout flushes any
// residue as a short burst. Datapath is a zero-latency pass-through.
module axis_burst_reader
   import axis_burst_reader_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEEP_BITS    = 5,
   parameter int BURST_BITS   = 4,
   parameter int TIMEOUT_BITS = 8
) (
   input  logic                    clk,
   input  logic                    axisrst_n,
   input  logic [WIDTH-1:0]        s_tdata,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic [DEEP_BITS-1:0]    fifo_used,
   input  logic                    fifo_empty,
   input  logic                    cfg_enable,
   input  logic [BURST_BITS-1:0]   cfg_burst_len,
   input  logic [TIMEOUT_BITS-1:0] cfg_timeout,
   output logic [WIDTH-1:0]        m_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic                    burst_active,
   output logic [CNT_W-1:0]        burst_count,
   output logic [CNT_W-1:0]        flush_count
);

   // Occupancy needs one extra bit: a full FIFO holds 2**DEEP_BITS words
   localparam int AV_W = DEEP_BITS + 1;

   state_e            state_q, state_d;
   logic [AV_W-1:0]   rem_q, rem_d;
   logic              flush_q, flush_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic [AV_W-1:0]   avail;
   logic [AV_W-1:0]   burst_len;
   logic              expired;
   logic              beat;
   logic              start;

   // Words buffered upstream and the configured burst length, both in beats
   always_comb begin
      avail     = fifo_empty ? '0 : (AV_W'(fifo_used) + AV_W'(1));
      burst_len = AV_W'(cfg_burst_len) + AV_W'(1);
      beat      = (state_q == ST_BURST) && s_tvalid && m_tready;
      start     = (state_q == ST_IDLE) && (state_d == ST_BURST);
   end

   axis_flush_timer #(
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) u_timer (
      .clk           (clk),
      .rst_n         (axisrst_n),
      .clear_i       (start),
      .count_i       (state_q == ST_IDLE),
      .avail_nz_i    (avail != '0),
      .cfg_timeout_i (cfg_timeout),
      .expired_o     (expired)
   );

   // State, remaining-beat count, flush flag and statistics registers
   always_ff @(posedge clk or negedge axisrst_n) begin
      if (!axisrst_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         flush_q     <= 1'b0;
         burst_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         flush_q     <= flush_d;
         burst_cnt_q <= burst_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state: full bursts win over flushes; length is latched at start
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      flush_d     = flush_q;
      burst_cnt_d = burst_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_enable && (avail >= burst_len)) begin
               state_d = ST_BURST;
               rem_d   = burst_len;
               flush_d = 1'b0;
            end else if (cfg_enable && expired) begin
               state_d = ST_BURST;
               rem_d   = avail;
               flush_d = 1'b1;
            end
         end
         ST_BURST: begin
            if (beat) begin
               rem_d = rem_q - AV_W'(1);
               if (rem_q == AV_W'(1)) begin
                  state_d     = ST_IDLE;
                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
                  if (flush_q) flush_cnt_d = flush_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: stream is gated by the FSM, data is never registered
   always_comb begin
      burst_active = (state_q == ST_BURST);
      m_tdata      = s_tdata;
      m_tvalid     = burst_active && s_tvalid;
      s_tready     = burst_active && m_tready;
      m_tlast      = burst_active && (rem_q == AV_W'(1));
      burst_count  = burst_cnt_q;
      flush_count  = flush_cnt_q;
   end

endmodule

// File: tb/tb_axis_burst_reader.sv
// Scoreboard bench for axis_burst_reader with a behavioural FIFO upstream.
module tb_axis_burst_reader;

   localparam int WIDTH = 32, DEEP_BITS = 5, BURST_BITS = 4, TIMEOUT_BITS = 8;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             l;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    axisrst_n;
   logic [WIDTH-1:0]        s_tdata = '0;
   logic                    s_tvalid = 1'b0;
   logic                    s_tready;
   logic [DEEP_BITS-1:0]    fifo_used = '0;
   logic                    fifo_empty = 1'b1;
   logic                    cfg_enable;
   logic [BURST_BITS-1:0]   cfg_burst_len;
   logic [TIMEOUT_BITS-1:0] cfg_timeout;
   logic [WIDTH-1:0]        m_tdata;
   logic                    m_tvalid;
   logic                    m_tready = 1'b1;
   logic                    m_tlast;
   logic                    burst_active;
   logic [15:0]             burst_count;
   logic [15:0]             flush_count;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   rnd_rdy = 1'b0;
   bit   prev_last = 1'b0;
   logic [WIDTH-1:0] fq[$];
   exp_t eq[$];

   axis_burst_reader dut (
      .clk           (clk),
      .axisrst_n     (axisrst_n),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .fifo_used     (fifo_used),
      .fifo_empty    (fifo_empty),
      .cfg_enable    (cfg_enable),
      .cfg_burst_len (cfg_burst_len),
      .cfg_timeout   (cfg_timeout),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .m_tlast       (m_tlast),
      .burst_active  (burst_active),
      .burst_count   (burst_count),
      .flush_count   (flush_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endfunction

   // Upstream FIFO model: pop on handshake, then present the new head
   always @(posedge clk) begin
      bit pop;
      pop = s_tready && s_tvalid;
      #1;
      if (pop && fq.size() != 0) void'(fq.pop_front());
      m_tready   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      fifo_empty = (fq.size() == 0);
      fifo_used  = (fq.size() == 0) ? '0 : DEEP_BITS'(fq.size() - 1);
      s_tvalid   = (fq.size() != 0);
      s_tdata    = (fq.size() != 0) ? fq[0] : '0;
   end

   // Monitor: every handshake must match the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (prev_last) chk("bubble_after_tlast", 32'(m_tvalid), 32'd0);
      prev_last = 1'b0;
      if (axisrst_n && m_tvalid && m_tready) begin
         if (eq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat data=%0h last=%0b", m_tdata, m_tlast);
         end else begin
            e = eq.pop_front();
            chk("beat_data", m_tdata, e.d);
            chk("beat_last", 32'(m_tlast), 32'(e.l));
         end
         prev_last = m_tlast;
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(logic [WIDTH-1:0] d, bit last);
      exp_t e;
      e.d = d;
      e.l = last;
      fq.push_back(d);
      eq.push_back(e);
   endtask

   task automatic wait_drain(string nm, int budget);
      int n = 0;
      while (eq.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk(nm, eq.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n0, n1, n;
      axisrst_n     = 1'b1;
      cfg_enable    = 1'b1;
      cfg_burst_len = 4'd3;
      cfg_timeout   = 8'd0;
      #1 axisrst_n = 1'b0;
      #1;
      chk("rst_m_tvalid", 32'(m_tvalid), 0);
      chk("rst_s_tready", 32'(s_tready), 0);
      chk("rst_m_tlast", 32'(m_tlast), 0);
      chk("rst_burst_active", 32'(burst_active), 0);
      chk("rst_burst_count", 32'(burst_count), 0);
      chk("rst_flush_count", 32'(flush_count), 0);
      step(3);
      axisrst_n = 1'b1;
      step(2);

      // 1: full 4-beat burst
      for (int i = 0; i < 4; i++) push(32'hA0 + i, i == 3);
      wait_drain("t1_drain", 50);
      chk("t1_burst_count", 32'(burst_count), 1);
      chk("t1_flush_count", 32'(flush_count), 0);

      // 2: 3 words left behind, flushed 11 cycles after becoming non-empty
      cfg_timeout = 8'd10;
      step(1);
      for (int i = 0; i < 3; i++) push(32'hB0 + i, i == 2);
      n = 0;
      do begin @(negedge clk); n++; end while (fifo_empty && n < 10);
      n0 = cyc;
      n = 0;
      while (!m_tvalid && n < 40) begin @(negedge clk); n++; end
      n1 = cyc;
      chk("t2_flush_latency", 32'(n1 - n0), 11);
      wait_drain("t2_drain", 50);
      chk("t2_burst_count", 32'(burst_count), 2);
      chk("t2_flush_count", 32'(flush_count), 1);

      // 3: timeout disabled, short residue never leaves
      cfg_timeout = 8'd0;
      step(2);
      for (int i = 0; i < 3; i++) push(32'hC0 + i, i == 2);
      step(1000);
      chk("t3_no_output", eq.size(), 3);
      chk("t3_burst_count", 32'(burst_count), 2);
      chk("t3_idle", 32'(burst_active), 0);
      cfg_timeout = 8'd5;
      wait_drain("t3_flush_drain", 50);
      chk("t3_flush_count", 32'(flush_count), 2);
      chk("t3_burst_count_after", 32'(burst_count), 3);

      // 4: 2-beat bursts under random backpressure
      cfg_timeout   = 8'd0;
      cfg_burst_len = 4'd1;
      rnd_rdy       = 1'b1;
      step(1);
      for (int i = 0; i < 6; i++) push(32'hD0 + i, (i % 2) == 1);
      wait_drain("t4_drain", 300);
      rnd_rdy = 1'b0;
      step(2);
      chk("t4_burst_count", 32'(burst_count), 6);
      chk("t4_flush_count", 32'(flush_count), 2);

      // 5: reset after two beats of a 4-beat burst
      cfg_burst_len = 4'd3;
      step(1);
      for (int i = 0; i < 4; i++) push(32'hE0 + i, i == 3);
      n = 0;
      do begin @(posedge clk); n++; end while (eq.size() > 2 && n < 30);
      #2 axisrst_n = 1'b0;
      #1;
      chk("t5_m_tvalid", 32'(m_tvalid), 0);
      chk("t5_m_tlast", 32'(m_tlast), 0);
      chk("t5_burst_active", 32'(burst_active), 0);
      chk("t5_burst_count", 32'(burst_count), 0);
      chk("t5_flush_count", 32'(flush_count), 0);
      step(1);
      axisrst_n = 1'b1;
      step(20);
      chk("t5_no_more_beats", eq.size(), 2);
      cfg_timeout = 8'd3;
      wait_drain("t5_flush_drain", 50);
      chk("t5_burst_count_after", 32'(burst_count), 1);
      chk("t5_flush_count_after", 32'(flush_count), 1);

      // 6: length change mid-burst only affects the following burst
      cfg_timeout   = 8'd0;
      cfg_burst_len = 4'd3;
      step(1);
      for (int i = 0; i < 12; i++) push(32'hF0 + i, i == 3 || i == 11);
      n = 0;
      while (!burst_active && n < 20) begin step(1); n++; end
      chk("t6_started", 32'(burst_active), 1);
      cfg_burst_len = 4'd7;
      wait_drain("t6_drain", 100);
      chk("t6_burst_count", 32'(burst_count), 3);
      chk("t6_flush_count", 32'(flush_count), 1);

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
